// File: rtl/neuro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuro_pkg
// Description : Shared definitions for the stream demultiplexer slice.
//               Provides the clog2 helper used to size channel selects and
//               the IDLE/BURST state encoding of the demux controller.
// Revision    : 1.0 - initial release
// ============================================================================
package neuro_pkg;

  // Demux controller state: IDLE waits for the first beat of a burst,
  // BURST holds the latched route until the last beat is accepted.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } demux_state_t;

  // Ceiling log2 with a floor of 1 so a select field is never zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : neuro_pkg
`default_nettype wire

// File: rtl/stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_if
// Description : Bundle of the demux input stream and the per-channel output
//               streams plus status flags.
//   in_valid/in_ready/in_data : upstream beat handshake and payload
//   in_sel/in_len             : burst route and length (first beat only)
//   out_valid/out_ready       : per-channel handshake, one bit per channel
//   out_data                  : channel k at [k*WIDTH +: WIDTH]
//   busy/err_sel              : burst-open flag, bad-select pulse
//   modport slave  : the demux side
//   modport master : the producer/consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 4
);
  localparam int SEL_W = neuro_pkg::clog2(NUM_OUT);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [CNT_W-1:0]         in_len;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic                     busy;
  logic                     err_sel;

  modport slave (
    input  in_valid, in_data, in_sel, in_len, out_ready,
    output in_ready, out_valid, out_data, busy, err_sel
  );

  modport master (
    output in_valid, in_data, in_sel, in_len, out_ready,
    input  in_ready, out_valid, out_data, busy, err_sel
  );

endinterface : stream_demux_if
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_chan_reg
// Description : Single-entry output register for one demux channel with
//               valid/ready semantics and zero-gated data output.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data this cycle (accepted beat for channel)
//   load_data  : beat payload
//   drain      : downstream ready for this channel
//   valid      : register holds a beat
//   data       : held beat, or zero when empty
// Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_reg #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_data,
  input  wire logic             drain,
  output logic                  valid,
  output logic [WIDTH-1:0]      data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain in the same cycle: the old beat leaves and the
  // new one takes its place, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  // Empty channels present zero rather than the last (stale) beat.
  assign data  = r_valid ? r_data : '0;

endmodule : demux_chan_reg
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : Steers one valid/ready stream to one of NUM_OUT channels a
//               burst at a time. Route and length come from the first beat;
//               the route holds until the burst's last beat is accepted.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_demux_if.slave (input stream, channel outputs, status)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  stream_demux_if.slave  bus
);
  import neuro_pkg::*;

  localparam int SEL_W = clog2(NUM_OUT);

  demux_state_t     r_state;
  demux_state_t     w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic [SEL_W-1:0] w_cs;
  logic             w_cs_ok;
  logic             w_tgt_valid;
  logic             w_tgt_ready;
  logic             w_in_ready;
  logic             w_accept;
  logic [NUM_OUT-1:0] w_load;

  logic             w_chan_valid [NUM_OUT];
  logic [WIDTH-1:0] w_chan_data  [NUM_OUT];

  // --------------------------------------------------------------------------
  // Target channel and input ready. In IDLE the route comes straight from the
  // beat on the bus; in BURST it comes from the latched select. A select that
  // names no channel is accepted unconditionally and its beats are dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cs        = (r_state == IDLE) ? bus.in_sel : r_sel;
    w_cs_ok     = 1'b0;
    w_tgt_valid = 1'b0;
    w_tgt_ready = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_cs == SEL_W'(k)) begin
        w_cs_ok     = 1'b1;
        w_tgt_valid = w_chan_valid[k];
        w_tgt_ready = bus.out_ready[k];
      end
    end
    w_in_ready = w_cs_ok ? (!w_tgt_valid || w_tgt_ready) : 1'b1;
    w_accept   = bus.in_valid && w_in_ready;
  end

  always_comb begin
    w_load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_load[k] = w_accept && (w_cs == SEL_W'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Burst controller. r_rem counts beats still owed after the first one; the
  // beat that brings it to zero closes the burst.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rem_nxt   = r_rem;
    w_err_nxt   = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          w_sel_nxt = bus.in_sel;
          // A zero length is a single-beat burst.
          w_rem_nxt = (bus.in_len == '0) ? '0 : (bus.in_len - CNT_W'(1));
          w_err_nxt = !w_cs_ok;
          if (w_rem_nxt != '0) begin
            w_state_nxt = BURST;
          end
        end
        BURST: begin
          w_rem_nxt = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel output registers.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[k]),
      .load_data (bus.in_data),
      .drain     (bus.out_ready[k]),
      .valid     (w_chan_valid[k]),
      .data      (w_chan_data[k])
    );
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.out_valid[k]                = w_chan_valid[k];
      bus.out_data[k*WIDTH +: WIDTH]  = w_chan_data[k];
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state == BURST);
  assign bus.err_sel  = r_err;

endmodule : stream_demux
`default_nettype wire

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Demultiplexer that steers one valid/ready data stream to one of NUM_OUT output channels, one burst at a time.
- Each burst's destination and length are captured from its first beat; the route holds until the burst completes.
- Each output channel has a single-entry register stage. A channel that holds no valid beat drives zero data, matching the gating-to-zero behaviour of the codebase's mux stages.
- Sits between the operand fetch stream and the per-PE input ports; it is the distribution end of the PE operand-select path.

Parameters:
- WIDTH, 16, data width per beat.
- NUM_OUT, 4, number of output channels (2..16).
- CNT_W, 4, width of the burst-length field; max burst = 2^CNT_W-1 beats.
- SEL_W, clog2(NUM_OUT), localparam, width of the channel select; minimum 1.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  input beat payload.
- in_sel  in  SEL_W  destination channel; sampled on the first beat of a burst only.
- in_len  in  CNT_W  burst length in beats; sampled on the first beat only; 0 is treated as 1.
- out_valid  out  NUM_OUT  per-channel valid.
- out_ready  in  NUM_OUT  per-channel ready.
- out_data  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- busy  out  1  high while a burst is open (state BURST).
- err_sel  out  1  one-cycle pulse when a burst is opened with in_sel >= NUM_OUT.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, all channel registers 0, state=IDLE, busy=0, err_sel=0.
  - Latched select=0, remaining count=0.
- State machine, IDLE / BURST:
  - IDLE, accepted beat: latch sel=in_sel and rem=max(in_len,1)-1. If rem==0, stay in IDLE (single-beat burst); otherwise go to BURST.
  - BURST, accepted beat: rem decrements; on the beat accepted with rem==0, return to IDLE.
  - in_sel and in_len are ignored while in BURST.
- in_ready, with cs = the target channel (in_sel when in IDLE, latched sel when in BURST):
  - Valid channel: in_ready = !out_valid[cs] || out_ready[cs]. This is a combinational path from out_ready; it is permitted.
  - Invalid channel (cs >= NUM_OUT): in_ready=1. Beats are consumed and dropped for the whole burst.
  - err_sel pulses once, in the cycle after the first beat of an invalid burst.
- Channel register k:
  - Loads in_data and sets out_valid[k] on an accepted beat with cs==k.
  - Clears out_valid[k] on out_ready[k] unless reloaded in the same cycle (simultaneous drain and load: keep valid=1, take the new data).
  - Latency: a beat accepted at cycle N appears on out_data[k] at N+1.
- out_data slice k = out_valid[k] ? reg[k] : 0. Unselected or empty channels never show stale data.
- Other channels drain independently while a burst targets channel k. Backpressure on channel k stalls only the input.
- Beat order within a channel is preserved. Bursts never interleave.
- Reset mid-burst: the burst is abandoned; there is no partial-burst recovery. Upstream re-sends from the burst start.

Decomposition:
- Shared package (neuro_pkg): clog2 function and the demux state enum (IDLE, BURST).
- One natural sub-module: demux_chan_reg, the single-entry register with valid/ready and zero-gated output, instantiated NUM_OUT times in a generate loop.
- FSM, counter and ready logic stay in the top module.

Test Plan:
- Single beat: in_sel=2, in_len=1, data 0x00A5, all out_ready=1 -> out_valid=4'b0100 and out_data[2]=0x00A5 one cycle later; busy stays 0; all other slices read 0.
- Burst: in_sel=1, in_len=3, data 0x11/0x22/0x33 with in_sel changed to 3 mid-burst -> all three beats arrive on channel 1 in order; busy high for 2 cycles after the first beat; the next beat routes to the in_sel value presented at that time.
- Backpressure: burst of 4 to channel 0 with out_ready[0] toggling 1,0,0,1 -> in_ready follows the ready rule; no beat lost or duplicated; a simultaneous drain and load keeps out_valid[0]=1 with the new data.
- Invalid select with NUM_OUT=3: in_sel=3, in_len=2 -> both beats accepted immediately; out_valid stays 0; err_sel pulses exactly once.
- in_len=0 -> treated as a 1-beat burst; FSM stays in IDLE.
- Reset mid-burst: rst_n low while rem=2 -> outputs 0 immediately (asynchronously); after release the next beat is treated as the first beat of a new burst.
